// File: rtl/result_drain.sv
// result_drain
//   Captures the full ROWS x ACC_W result vector from the mesh array in one cycle on a
//   capture pulse, then streams it out one row per beat over valid/ready. Each row is
//   requantized to OUT_W bits (rounding arithmetic right shift, then signed saturation).
//   Capturing into a local buffer frees the array for its next job while the host drains.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   capture      1-cycle pulse, result_flat and shift valid this cycle
//   result_flat  signed results, row r at [r*ACC_W +: ACC_W]
//   shift        right-shift amount, sampled with capture
//   out_valid    out_data/out_row/out_last valid
//   out_ready    consumer accepts beat when out_valid && out_ready
//   out_data     requantized signed row value (registered)
//   out_row      row index of current beat
//   out_last     high on the beat of row ROWS-1
//   busy         buffer holds undrained rows
//   drop         1-cycle pulse, capture ignored because busy

module result_drain #(
    parameter int ROWS    = 8,
    parameter int ROW_W   = 3,
    parameter int ACC_W   = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [ROWS*ACC_W-1:0] result_flat,
    input  logic [SHIFT_W-1:0]    shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [ROW_W-1:0]      out_row,
    output logic                  out_last,
    output logic                  busy,
    output logic                  drop
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic                  state_q;
    logic [ROWS*ACC_W-1:0] buf_q;
    logic [SHIFT_W-1:0]    shift_q;
    logic [OUT_W-1:0]      data_q;
    logic [ROW_W-1:0]      row_q;
    logic                  drop_q;

    logic                  xfer;
    logic                  last_xfer;
    logic                  load;
    logic                  drop_d;
    logic [ROW_W-1:0]      row_inc;
    logic [SHIFT_W-1:0]    shift_clamp;

    // Requantizer datapath
    logic [ACC_W-1:0]        q_src;
    logic [SHIFT_W-1:0]      q_shift;
    logic signed [ACC_W:0]   q_ext;
    logic signed [ACC_W:0]   q_inc;
    logic signed [ACC_W:0]   q_rnd;
    logic signed [ACC_W:0]   q_shd;
    logic [OUT_W-1:0]        q_out;

    assign xfer      = (state_q == ST_STREAM) && out_ready;
    assign last_xfer = xfer && (row_q == LAST_ROW);
    // A capture coinciding with the final transfer is accepted so jobs can run back to back.
    assign load      = capture && ((state_q == ST_IDLE) || last_xfer);
    assign drop_d    = capture && (state_q == ST_STREAM) && !last_xfer;
    assign row_inc   = row_q + ROW_W'(1);

    assign shift_clamp = (int'(shift) > ACC_W - 1) ? SHIFT_W'(ACC_W - 1) : shift;

    // On a load the first beat comes straight from the input vector, since the buffer
    // is only written on the same edge.
    always_comb begin
        q_src   = buf_q[row_inc*ACC_W +: ACC_W];
        q_shift = shift_q;
        if (load) begin
            q_src   = result_flat[ACC_W-1:0];
            q_shift = shift_clamp;
        end

        // One extra bit of headroom so adding the rounding constant cannot wrap.
        q_ext = {q_src[ACC_W-1], q_src};
        q_inc = '0;
        if (q_shift != '0) begin
            q_inc = (ACC_W + 1)'(1) << (q_shift - SHIFT_W'(1));
        end
        q_rnd = q_ext + q_inc;
        q_shd = q_rnd >>> q_shift;

        if (q_shd > SAT_MAX) begin
            q_out = SAT_MAX[OUT_W-1:0];
        end else if (q_shd < SAT_MIN) begin
            q_out = SAT_MIN[OUT_W-1:0];
        end else begin
            q_out = q_shd[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            row_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= drop_d;
            if (load) begin
                state_q <= ST_STREAM;
                buf_q   <= result_flat;
                shift_q <= shift_clamp;
                row_q   <= '0;
                data_q  <= q_out;
            end else if (last_xfer) begin
                state_q <= ST_IDLE;
                row_q   <= '0;
            end else if (xfer) begin
                row_q  <= row_inc;
                data_q <= q_out;
            end
        end
    end

    assign out_valid = (state_q == ST_STREAM);
    assign busy      = (state_q == ST_STREAM);
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_last  = (row_q == LAST_ROW);
    assign drop      = drop_q;

endmodule
